// File: rtl/instr_fetch_queue_if.sv
// ============================================================================
// Module  : instr_fetch_queue_pkg / instr_fetch_queue_if
// Purpose : Entry types and the fetch/issue-side signal bundle of the fetch queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef logic [1:0] fetch_ack_t;
endpackage

interface instr_fetch_queue_if #(
    parameter int DEPTH = 8
);
    import instr_fetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic                    flush;
    logic [1:0]              push_valid;
    fetch_entry_t [1:0]      push_entry;
    logic                    push_ready;
    fetch_entry_t [1:0]      fetch_entry;
    fetch_ack_t              fetch_ack;
    logic [CW-1:0]           count;

    // Fetch/issue side drives the strobes; the queue drives status and head entries.
    modport master (
        output flush, push_valid, push_entry, fetch_ack,
        input  push_ready, fetch_entry, count
    );

    modport slave (
        input  flush, push_valid, push_entry, fetch_ack,
        output push_ready, fetch_entry, count
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module  : instr_fetch_queue
// Purpose : Two-in / two-out circular decoupling buffer between fetch and issue.
//           Optional empty-queue forwarding enabled by FETCH_QUEUE_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    instr_fetch_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_READY_MAX = CW'(DEPTH - 2);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_count;

    logic          w_ready;
    logic          w_accept;
    logic [1:0]    w_npush;
    logic [1:0]    w_avail;
    logic [1:0]    w_pop;
    logic [1:0]    w_skip;
    logic          w_wr0;
    logic          w_wr1;
    logic [PW-1:0] w_rptr1;
    logic [PW-1:0] w_wptr1;
    fetch_entry_t  w_slot0;
    fetch_entry_t  w_slot1;
    fetch_entry_t  w_mem0;
    fetch_entry_t  w_mem1;

    // Readiness depends on registered occupancy only, never on this cycle's ack.
    assign w_ready  = (r_count <= c_READY_MAX);
    assign w_accept = w_ready && !bus.flush;
    assign w_npush  = !w_accept     ? 2'd0 :
                      bus.push_valid[1] ? 2'd2 :
                      bus.push_valid[0] ? 2'd1 : 2'd0;

    assign w_rptr1 = r_rptr + PW'(1);
    assign w_wptr1 = r_wptr + PW'(1);

    always_comb begin
        w_mem0       = r_mem[r_rptr];
        w_mem0.valid = 1'b1;
        w_mem1       = r_mem[w_rptr1];
        w_mem1.valid = 1'b1;
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    always_comb begin
        w_slot0 = '0;
        w_slot1 = '0;
        w_avail = 2'd0;
        if (r_count >= CW'(2)) begin
            w_slot0 = w_mem0;
            w_slot1 = w_mem1;
            w_avail = 2'd2;
        end else if (r_count == CW'(1)) begin
            w_slot0 = w_mem0;
            w_avail = 2'd1;
            if (!bus.flush && bus.push_valid[0]) begin
                w_slot1       = bus.push_entry[0];
                w_slot1.valid = 1'b1;
                w_avail       = 2'd2;
            end
        end else if (!bus.flush) begin
            if (bus.push_valid[0]) begin
                w_slot0       = bus.push_entry[0];
                w_slot0.valid = 1'b1;
                w_avail       = 2'd1;
            end
            if (bus.push_valid[1]) begin
                w_slot1       = bus.push_entry[1];
                w_slot1.valid = 1'b1;
                w_avail       = 2'd2;
            end
        end
    end

    // Forwarded entries consumed this cycle are never stored; the read pointer
    // still advances past their positions so pointer and count stay coherent.
    always_comb begin
        w_skip = 2'd0;
        if (r_count < CW'(2) && CW'(w_pop) > r_count)
            w_skip = w_pop - r_count[1:0];
    end
`else
    always_comb begin
        w_slot0 = '0;
        w_slot1 = '0;
        w_avail = 2'd0;
        if (r_count >= CW'(1)) begin
            w_slot0 = w_mem0;
            w_avail = 2'd1;
        end
        if (r_count >= CW'(2)) begin
            w_slot1 = w_mem1;
            w_avail = 2'd2;
        end
    end

    assign w_skip = 2'd0;
`endif

    assign w_pop = (bus.fetch_ack > w_avail) ? w_avail : bus.fetch_ack;

    assign w_wr0 = w_accept && bus.push_valid[0] && (w_skip == 2'd0);
    assign w_wr1 = w_accept && bus.push_valid[1] && (w_skip != 2'd2);

    assign bus.fetch_entry[0] = w_slot0;
    assign bus.fetch_entry[1] = w_slot1;
    assign bus.push_ready     = w_ready;
    assign bus.count          = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_rptr  <= r_rptr + PW'(w_pop);
            r_wptr  <= r_wptr + PW'(w_npush);
            r_count <= r_count + CW'(w_npush) - CW'(w_pop);
        end
    end

    // Storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_wr0)
            r_mem[r_wptr] <= bus.push_entry[0];
        if (w_wr1)
            r_mem[w_wptr1] <= bus.push_entry[1];
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// Module  : tb_instr_fetch_queue
// Purpose : Directed plus randomized checks of instr_fetch_queue against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_vec = 0;
    int           n_err = 0;
    fetch_entry_t mq[$];
    logic [31:0]  pc_next = 32'h1000;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected head window: stored entries, plus forwarded pushes when bypass is built in.
    task automatic check_outputs(input string tag);
        fetch_entry_t vis[$];
        fetch_entry_t e;
        fetch_entry_t expv [2];
        vis = mq;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!bus.flush && mq.size() < 2) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.push_valid[i]) begin
                    e       = bus.push_entry[i];
                    e.valid = 1'b1;
                    vis.push_back(e);
                end
            end
        end
`endif
        for (int i = 0; i < 2; i++)
            expv[i] = (i < vis.size()) ? vis[i] : '0;
        chk({tag, ".count"}, 128'(bus.count), 128'(mq.size()));
        chk({tag, ".ready"}, 128'(bus.push_ready), 128'((DEPTH - mq.size()) >= 2));
        chk({tag, ".slot0"}, 128'(bus.fetch_entry[0]), 128'(expv[0]));
        chk({tag, ".slot1"}, 128'(bus.fetch_entry[1]), 128'(expv[1]));
    endtask

    // Called at a negedge: drive, check, advance model at posedge, return at next negedge.
    task automatic step(input string tag, input logic fl, input logic [1:0] pv, input logic [1:0] ack);
        fetch_entry_t e0, e1;
        bit           ready;
        int           avail, pop;
        e0 = '{valid: 1'($urandom), pc: pc_next,         instr: $urandom};
        e1 = '{valid: 1'($urandom), pc: pc_next + 32'd4, instr: $urandom};
        pc_next             = pc_next + 32'd8;
        bus.flush           = fl;
        bus.push_valid      = pv;
        bus.push_entry[0]   = e0;
        bus.push_entry[1]   = e1;
        bus.fetch_ack       = ack;
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            ready = (DEPTH - mq.size()) >= 2;
`ifndef FETCH_QUEUE_BYPASS_EN
            avail = (mq.size() < 2) ? mq.size() : 2;
`endif
            if (ready) begin
                e0.valid = 1'b1;
                e1.valid = 1'b1;
                if (pv[0]) mq.push_back(e0);
                if (pv[1]) mq.push_back(e1);
            end
`ifdef FETCH_QUEUE_BYPASS_EN
            avail = (mq.size() < 2) ? mq.size() : 2;
`endif
            pop = (int'(ack) < avail) ? int'(ack) : avail;
            repeat (pop) void'(mq.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] pvr;
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.push_valid = 2'b00;
        bus.push_entry = '0;
        bus.fetch_ack  = 2'd0;
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two entries held through ack=0, then drained by ack=2.
        step("push2", 1'b0, 2'b11, 2'd0);
        chk("pc0_1000", 128'(bus.fetch_entry[0].pc), 128'(32'h1000));
        chk("pc1_1004", 128'(bus.fetch_entry[1].pc), 128'(32'h1004));
        repeat (3) step("hold", 1'b0, 2'b00, 2'd0);
        step("ack2", 1'b0, 2'b00, 2'd2);
        check_outputs("drained");

        // Fill to 7 then 8, push while not ready is dropped.
        repeat (3) step("fill", 1'b0, 2'b11, 2'd0);
        step("fill7", 1'b0, 2'b01, 2'd0);
        chk("count7", 128'(bus.count), 128'(7));
        chk("ready7", 128'(bus.push_ready), 128'(0));
        step("drop7", 1'b0, 2'b11, 2'd0);
        step("ack1", 1'b0, 2'b00, 2'd1);
        step("fill8", 1'b0, 2'b11, 2'd0);
        chk("count8", 128'(bus.count), 128'(DEPTH));
        step("drop8", 1'b0, 2'b11, 2'd0);
        check_outputs("full");

        // Flush wins over same-cycle push and pop.
        step("flush", 1'b1, 2'b11, 2'd2);
        check_outputs("postflush");

        // Push 2 / ack 1 steady state across pointer wrap.
        repeat (7) step("steady", 1'b0, 2'b11, 2'd1);
        step("flush2", 1'b1, 2'b00, 2'd0);

        // Over-ack with a single entry clamps to one pop.
        step("one", 1'b0, 2'b01, 2'd0);
        step("overack", 1'b0, 2'b00, 2'd2);
        check_outputs("clamped");
        step("after_clamp", 1'b0, 2'b11, 2'd0);

        // Count 5 with push, ack and flush together.
        step("c5a", 1'b0, 2'b11, 2'd0);
        step("c5b", 1'b0, 2'b01, 2'd0);
        step("c5flush", 1'b1, 2'b11, 2'd2);
        check_outputs("c5done");

`ifdef FETCH_QUEUE_BYPASS_EN
        pc_next = 32'h2000;
        step("byp", 1'b0, 2'b11, 2'd1);
        chk("byp_count1", 128'(bus.count), 128'(1));
        chk("byp_pc2004", 128'(bus.fetch_entry[0].pc), 128'(32'h2004));
        step("byp_flush", 1'b1, 2'b00, 2'd0);
`endif

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 2))
                0:       pvr = 2'b00;
                1:       pvr = 2'b01;
                default: pvr = 2'b11;
            endcase
            step("rand", ($urandom_range(0, 40) == 0), pvr, 2'($urandom_range(0, 2)));
        end

        // Asynchronous reset mid-cycle clears outputs immediately.
        step("prefill", 1'b0, 2'b11, 2'd0);
        bus.push_valid = 2'b00;
        bus.fetch_ack  = 2'd0;
        bus.flush      = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b0, 2'b11, 2'd0);
        check_outputs("post_rst_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
